ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Shares the single data RAM between two masters.
- Requester 0 is the CPU sequence controller, which does instruction fetch and LOAD/STORE data access.
- Requester 1 is the port DMA engine.
- The block arbitrates requests (round-robin or fixed priority), drives the RAM strobes with a programmable number of wait states, captures read data, and returns a one-cycle ACK to the winner.

Parameters:
- AW, 7, address width.
- DW, 8, data width.
- WAIT_STATES, 1, extra ACCESS cycles per transfer; legal range 0..15.
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  reset; asynchronous, active-low.
- REQ0, REQ1  input  1 each  access request, level, held until ACK.
- WE0, WE1  input  1 each  1 = write, 0 = read; stable while REQ high.
- ADDR0, ADDR1  input  AW each  access address; stable while REQ high.
- WDATA0, WDATA1  input  DW each  write data; stable while REQ high.
- ACK0, ACK1  output  1 each  one-cycle completion pulse.
- GNT0, GNT1  output  1 each  owner of the current transfer; high from ACCESS through DONE.
- RDATA  output  DW  read data captured at end of ACCESS; valid when ACK pulses for a read.
- BUSY  output  1  high when state is not IDLE.
- RAM_CS, RAM_OE, RAM_WE  output  1 each  RAM strobes, registered, active-high.
- RAM_ADDR  output  AW  registered RAM address.
- RAM_WDATA  output  DW  registered RAM write data.
- RAM_RDATA  input  DW  RAM read data; valid during the last ACCESS cycle.

Behaviour:
- Reset (async, RESET low):
  - state = IDLE; PRIO = 0; wait counter = 0.
  - All outputs 0, including RDATA, RAM_ADDR and RAM_WDATA.
  - Reset mid-transfer aborts immediately. No ACK is issued; strobes drop without waiting for a clock.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any REQ is high, select winner g and latch GNTg, ADDRg, WDATAg, WEg into the RAM_* registers.
  - Set RAM_CS = 1, RAM_OE = !WEg, RAM_WE = WEg; load counter = WAIT_STATES; go to ACCESS.
- Arbitration:
  - One request high → that requester wins.
  - Both high, FIXED_PRIO = 1 → requester 0 wins.
  - Both high, FIXED_PRIO = 0 → requester PRIO wins; on every grant PRIO <= !g.
- ACCESS:
  - Strobes, address and data are held constant.
  - If counter ≠ 0, decrement it.
  - If counter == 0: when read, RDATA <= RAM_RDATA; clear all RAM_* strobes; set ACKg = 1; go to DONE.
- DONE:
  - ACKg is high for exactly this cycle; GNTg stays high.
  - Next edge: ACK = 0, GNT = 0, go to IDLE.
- Latency:
  - Cycle 0 is the IDLE cycle in which REQ is sampled.
  - ACCESS occupies cycles 1 .. WAIT_STATES+1.
  - ACK is high in cycle WAIT_STATES+2.
  - Back-to-back throughput is one transfer per WAIT_STATES+3 cycles.
- Handshake:
  - The requester deasserts REQ on the edge where it samples ACK.
  - A REQ still high in the following IDLE cycle is treated as a new transfer.
  - A REQ dropped mid-transfer does not abort it; the transfer completes and ACK still pulses.
  - A losing requester waits in IDLE with REQ held and is not starved in round-robin mode.
- Exclusivity:
  - GNT0 & GNT1, ACK0 & ACK1, and RAM_OE & RAM_WE are never high together.
  - RAM_OE and RAM_WE are only ever high while RAM_CS is high.
- RDATA:
  - Holds its value through writes and idle periods.
  - Changes only on read completion.
- Wrap-around: WAIT_STATES = 0 gives a single ACCESS cycle. The counter never underflows.

Test Plan:
- Read (WAIT_STATES = 1): REQ0 = 1, WE0 = 0, ADDR0 = 7'h40, RAM_RDATA = 8'hA5.
  - Expect RAM_CS = RAM_OE = 1 and RAM_ADDR = 7'h40 in cycles 1–2.
  - Expect ACK0 = 1 and RDATA = 8'hA5 in cycle 3; ACK1 = 0 throughout.
- Write (WAIT_STATES = 0): REQ1 = 1, WE1 = 1, ADDR1 = 7'h43, WDATA1 = 8'h3C.
  - Expect RAM_WE = 1, RAM_OE = 0, RAM_WDATA = 8'h3C in cycle 1; ACK1 = 1 in cycle 2.
  - RDATA unchanged from its previous value.
- Contention, round-robin: REQ0 and REQ1 held high continuously, re-asserted after each ACK.
  - Grants alternate 0, 1, 0, 1 over 4 transfers; no two ACKs are adjacent.
- Contention, FIXED_PRIO = 1: same stimulus.
  - Requester 0 wins every transfer; GNT1 stays 0.
- Reset mid-transfer: assert REQ0; pull RESET low in cycle 1 between clock edges.
  - RAM_CS, GNT0 and BUSY drop to 0 asynchronously; no ACK0 is issued.
  - After release, the held REQ0 completes one full transfer.
- Dropped request: REQ1 deasserted in cycle 1 of a read.
  - Transfer still completes; ACK1 pulses once; state returns to IDLE with BUSY = 0.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Two-master arbiter for the shared data RAM: CPU sequencer (requester 0) and port DMA (requester 1).
// Grants one transfer at a time, drives registered RAM strobes with programmable wait states, returns a one-cycle ACK.
//
// state  | meaning
// IDLE   | sampling REQ0/REQ1, strobes low
// ACCESS | RAM strobes held, wait counter running down
// DONE   | ACK pulse to winner, grant still held
module ram_access_arbiter #(
  parameter int AW          = 7,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          GNT0,
  output logic          GNT1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          RAM_CS,
  output logic          RAM_OE,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_WDATA,
  input  logic [DW-1:0] RAM_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ram_cs_q, ram_cs_d, ram_oe_q, ram_oe_d, ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          win0;
  logic          we_sel;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    ram_cs_d    = ram_cs_q;
    ram_oe_d    = ram_oe_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    // requester 0 wins when alone, under fixed priority, or when it holds the round-robin token
    win0   = REQ0 && (!REQ1 || (FIXED_PRIO != 0) || !prio_q);
    we_sel = win0 ? WE0 : WE1;
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          gnt0_d      = win0;
          gnt1_d      = !win0;
          ram_addr_d  = win0 ? ADDR0 : ADDR1;
          ram_wdata_d = win0 ? WDATA0 : WDATA1;
          ram_cs_d    = 1'b1;
          ram_oe_d    = !we_sel;
          ram_we_d    = we_sel;
          cnt_d       = 4'(WAIT_STATES);
          prio_d      = win0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (ram_oe_q) rdata_d = RAM_RDATA;
          ram_cs_d = 1'b0;
          ram_oe_d = 1'b0;
          ram_we_d = 1'b0;
          ack0_d   = gnt0_q;
          ack1_d   = gnt1_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= 4'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      ram_cs_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      ram_cs_q    <= ram_cs_d;
      ram_oe_q    <= ram_oe_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign RDATA     = rdata_q;
  assign BUSY      = (state_q != IDLE);
  assign RAM_CS    = ram_cs_q;
  assign RAM_OE    = ram_oe_q;
  assign RAM_WE    = ram_we_q;
  assign RAM_ADDR  = ram_addr_q;
  assign RAM_WDATA = ram_wdata_q;

endmodule
